// File: rtl/pri_sel_comb_blk_pkg.sv
// ---------------------------------------------------------------------------
// pri_sel_pkg
// Shared constants and helpers for the pSLIP priority selector slice.
//   N_DEF / P_DEF : default input count and number of priority levels
//   W_DEF         : width of one priority value for the default P
//   pri_t         : priority value type for the default P
//   cyc_inc()     : cyclic index increment, (idx + 1) mod n
// ---------------------------------------------------------------------------
package pri_sel_pkg;

    localparam int N_DEF = 4;
    localparam int P_DEF = 16;
    localparam int W_DEF = $clog2(P_DEF);

    typedef logic [W_DEF-1:0] pri_t;

    // Next index after idx in a ring of n slots; the last slot wraps to 0.
    function automatic int cyc_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pri_sel_comb_blk_if.sv
// ---------------------------------------------------------------------------
// pri_sel_comb_blk_if
// Bundles the selector's data path: per-input priorities in, and the
// maximum value plus one-hot grant out.
//   in[0:N-1] : per-input priority value, 0 means "no request"
//   out       : maximum priority value, 0 when nothing requests
//   req_out   : one-hot grant naming the winning input
// Modports:
//   master : request-priority logic side (drives in, observes results)
//   slave  : selector side (reads in, drives out/req_out)
// ---------------------------------------------------------------------------
interface pri_sel_comb_blk_if
    import pri_sel_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
);

    logic [W-1:0] in [0:N-1];
    logic [W-1:0] out;
    logic [N-1:0] req_out;

    modport master (output in, input out, input req_out);
    modport slave  (input in, output out, output req_out);

endinterface

// File: rtl/pri_sel_comb_blk_rr_tie_arb.sv
// ---------------------------------------------------------------------------
// rr_tie_arb
// Round-robin tie breaker. Among the candidate inputs (those holding the
// current maximum) picks the first one found searching cyclically from ptr.
// Ports:
//   cand    : N-bit candidate mask, bit i set when input i holds the maximum
//   ptr     : search start index
//   grant   : one-hot grant, all-zero when no candidate is set
//   win_idx : index of the granted input (0 when nothing is granted)
// ---------------------------------------------------------------------------
module rr_tie_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         cand,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] win_idx
);

    localparam int PW = $clog2(N);
    localparam logic [PW:0] N_W = (PW+1)'(N);

    logic          found;
    logic [PW:0]   pos;

    // Walk the ring starting at ptr; one extra bit on pos lets the
    // sum ptr+k exceed N-1 before it is folded back into range.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end
            if (!found && cand[pos[PW-1:0]]) begin
                found                = 1'b1;
                grant[pos[PW-1:0]]   = 1'b1;
                win_idx              = pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/pri_sel_comb_blk.sv
// ---------------------------------------------------------------------------
// pri_sel_comb_blk
// Priority selector for the pSLIP scheduler. Reports the largest priority
// among N inputs and a one-hot grant for the winner; ties are broken by a
// round-robin pointer that moves just past each granted input.
// Ports:
//   clk   : system clock, pointer updates on the rising edge
//   reset : synchronous active-high reset, returns the pointer to 0
//   bus   : slave side of pri_sel_comb_blk_if (in[] / out / req_out)
// Build option:
//   PRI_SEL_REG_OUT_EN : when defined, out/req_out are registered (one cycle
//                        of latency, reset to 0); the pointer still follows
//                        the pre-register grant. Undefined: outputs are
//                        purely combinational from in[] and the pointer.
// ---------------------------------------------------------------------------
module pri_sel_comb_blk
    import pri_sel_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int P = P_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    pri_sel_comb_blk_if.slave       bus
);

    localparam int W  = $clog2(P);
    localparam int PW = $clog2(N);

    logic [W-1:0]  max_v;
    logic [N-1:0]  cand;
    logic [N-1:0]  grant;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] ptr;

    // Unsigned maximum over all inputs; stays 0 when nobody requests.
    always_comb begin
        max_v = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.in[i] > max_v) begin
                max_v = bus.in[i];
            end
        end
    end

    // Inputs tied at the maximum. A zero maximum is not a request, so the
    // mask is cleared and the arbiter grants nothing.
    always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand[i] = (bus.in[i] == max_v) && (max_v != '0);
        end
    end

    rr_tie_arb #(.N(N)) u_arb (
        .cand    (cand),
        .ptr     (ptr),
        .grant   (grant),
        .win_idx (win_idx)
    );

    // Tie-break pointer: moves to the slot after the winner whenever a grant
    // is issued, so equal requesters take turns; holds when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant != '0) begin
            ptr <= PW'(cyc_inc(int'(win_idx), N));
        end
    end

`ifdef PRI_SEL_REG_OUT_EN
    // Registered outputs for timing closure in the grant/accept path.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out     <= '0;
            bus.req_out <= '0;
        end else begin
            bus.out     <= max_v;
            bus.req_out <= grant;
        end
    end
`else
    assign bus.out     = max_v;
    assign bus.req_out = grant;
`endif

endmodule

// File: tb/tb_pri_sel_comb_blk.sv
// ---------------------------------------------------------------------------
// tb_pri_sel_comb_blk
// Self-checking bench for the default (combinational output) build of
// pri_sel_comb_blk with N=4, P=16. Directed vector table, a hand-written
// sequence for inputs changing between edges, then random vectors checked
// against a small reference model of the selector.
// ---------------------------------------------------------------------------
module tb_pri_sel_comb_blk;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   model_ptr;

    pri_sel_comb_blk_if #(.N(4), .W(4)) bus ();

    pri_sel_comb_blk #(.N(4), .P(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One directed step: inputs/reset held for one cycle, outputs expected
    // before the rising edge that ends that cycle.
    typedef struct {
        logic            rst;
        logic [3:0][3:0] v;
        logic [3:0]      e_out;
        logic [3:0]      e_req;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic rst, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d,
                                input logic [3:0] eo, input logic [3:0] er);
        vec_t r;
        r.rst   = rst;
        r.v     = {d, c, b, a};
        r.e_out = eo;
        r.e_req = er;
        return r;
    endfunction

    // Drive a new input set just after a falling edge, then let it settle.
    task automatic applyStimulus(input logic rst, input logic [3:0][3:0] v);
        @(negedge clk);
        reset = rst;
        for (int i = 0; i < 4; i++) bus.in[i] = v[i];
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eo, input logic [3:0] er);
        total++;
        if (bus.out !== eo) begin
            bad++;
            $display("[TB] FAIL %s out: got %0d expected %0d", name, bus.out, eo);
        end
        total++;
        if (bus.req_out !== er) begin
            bad++;
            $display("[TB] FAIL %s req_out: got %b expected %b", name, bus.req_out, er);
        end
    endtask

    // Reference selector: max, then cyclic search from the model pointer.
    task automatic modelSel(input logic [3:0][3:0] v, output logic [3:0] eo,
                            output logic [3:0] er, output int w);
        eo = 4'd0;
        er = 4'd0;
        w  = -1;
        for (int i = 0; i < 4; i++) if (v[i] > eo) eo = v[i];
        if (eo != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (model_ptr + k) % 4;
                if (w < 0 && v[j] == eo) w = j;
            end
            er[w] = 1'b1;
        end
    endtask

    initial begin
        logic [3:0][3:0] rv;
        logic [3:0]      eo;
        logic [3:0]      er;
        int              w;
        logic            rrst;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) bus.in[i] = 4'd0;

        vecs[0]  = mk(1, 0, 0, 0, 0,  0, 4'b0000);   // reset, idle
        vecs[1]  = mk(0, 3, 9, 5, 1,  9, 4'b0010);   // unique max -> ptr 2
        vecs[2]  = mk(1, 7, 7, 0, 7,  7, 4'b1000);   // ptr 2 search, reset -> ptr 0
        vecs[3]  = mk(0, 7, 7, 0, 7,  7, 4'b0001);   // tie rotation
        vecs[4]  = mk(0, 7, 7, 0, 7,  7, 4'b0010);
        vecs[5]  = mk(0, 7, 7, 0, 7,  7, 4'b1000);
        vecs[6]  = mk(0, 7, 7, 0, 7,  7, 4'b0001);   // ptr -> 1
        vecs[7]  = mk(0, 0, 0, 0, 0,  0, 4'b0000);   // idle, ptr holds at 1
        vecs[8]  = mk(0, 0, 0, 0, 0,  0, 4'b0000);
        vecs[9]  = mk(0, 0, 0, 0, 0,  0, 4'b0000);
        vecs[10] = mk(0, 7, 7, 0, 7,  7, 4'b0010);   // resumes at 1 -> ptr 2
        vecs[11] = mk(0, 0, 0, 9, 0,  9, 4'b0100);   // -> ptr 3
        vecs[12] = mk(0, 15, 2, 2, 15, 15, 4'b1000); // wrap: ptr 3 -> 0
        vecs[13] = mk(0, 15, 2, 2, 15, 15, 4'b0001); // -> ptr 1
        vecs[14] = mk(0, 4, 4, 4, 4,  4, 4'b0010);   // -> ptr 2
        vecs[15] = mk(1, 4, 4, 4, 4,  4, 4'b0100);   // reset mid-op -> ptr 0
        vecs[16] = mk(0, 4, 4, 4, 4,  4, 4'b0001);   // all equal rotation
        vecs[17] = mk(0, 4, 4, 4, 4,  4, 4'b0010);
        vecs[18] = mk(0, 4, 4, 4, 4,  4, 4'b0100);
        vecs[19] = mk(0, 4, 4, 4, 4,  4, 4'b1000);
        vecs[20] = mk(0, 4, 4, 4, 4,  4, 4'b0001);   // -> ptr 1

        for (int k = 0; k < 21; k++) begin
            applyStimulus(vecs[k].rst, vecs[k].v);
            checkOutput($sformatf("vec%0d", k), vecs[k].e_out, vecs[k].e_req);
        end

        // Inputs change between edges: the pointer samples the grant that is
        // present at the edge, not the one seen earlier in the cycle (ptr=1).
        applyStimulus(1'b0, {4'd5, 4'd5, 4'd5, 4'd5});
        checkOutput("midcyc_a", 4'd5, 4'b0010);
        #2;
        for (int i = 0; i < 4; i++) bus.in[i] = (i == 3) ? 4'd6 : 4'd0;
        #1;
        checkOutput("midcyc_b", 4'd6, 4'b1000);
        applyStimulus(1'b0, {4'd5, 4'd5, 4'd5, 4'd5});
        checkOutput("midcyc_c", 4'd5, 4'b0001);

        // Random phase, synchronised by a reset cycle with no requests.
        applyStimulus(1'b1, '0);
        checkOutput("rnd_sync", 4'd0, 4'b0000);
        model_ptr = 0;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 4; i++) begin
                rv[i] = (n % 3 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            end
            rrst = ($urandom_range(0, 49) == 0);
            applyStimulus(rrst, rv);
            modelSel(rv, eo, er, w);
            checkOutput($sformatf("rnd%0d", n), eo, er);
            if (rrst) model_ptr = 0;
            else if (w >= 0) model_ptr = (w + 1) % 4;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pri_sel_comb_blk.md
Name: pri_sel_comb_blk

Overview:
- Combinational priority selector for the pSLIP scheduler.
- Takes N priority/level values and reports the maximum value (`out`) plus a one-hot grant (`req_out`) naming the winning input.
- Ties among inputs holding the maximum are broken by a registered round-robin pointer. That pointer is the only sequential state.
- Sits between per-port request-priority logic and the grant/accept stages.

Parameters:
- N, 4, number of inputs to select among (N >= 2).
- P, 16, number of priority levels; each value is W = $clog2(P) bits wide (default W = 4).

Ports:
- clk  input  1  system clock; pointer updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  [W-1:0] x N (unpacked array, in[0:N-1])  per-input priority value; value 0 means "no request".
- out  output  W  maximum value among in[]; 0 when no request.
- req_out  output  N  one-hot grant; bit i selects in[i]; all-zero when no request.

Behaviour:
- Default build is combinational from `in` and `ptr` to `out`/`req_out`, with zero latency.
- `ptr` is an internal register of $clog2(N) bits, holding the tie-break start index.
- Selection:
  - max = largest in[i], compared unsigned.
  - If max == 0: out = 0 and req_out = 0.
  - Otherwise out = max.
  - req_out has exactly one bit set: the first index w, searching cyclically ptr, ptr+1, …, N-1, 0, …, ptr-1, such that in[w] == max.
- Pointer update, each rising clk edge:
  - If reset: ptr <= 0.
  - Else if req_out != 0: ptr <= (w+1) mod N. Wrap-around applies: w = N-1 gives ptr = 0.
  - Else: ptr holds.
- Reset output values: outputs are combinational, so during reset they still reflect `in`, evaluated with ptr = 0 once the reset edge has occurred.
- Reset mid-operation: the pointer returns to 0 on the next edge. No other state exists.
- Unique maximum: the pointer does not affect which input wins, but it still advances past the winner.
- All inputs equal and nonzero: the grant rotates 0, 1, 2, …, N-1, 0 on successive cycles.
- `in` changing between edges: outputs follow immediately, and `ptr` samples the `req_out` present at the edge.
- No X propagation on legal inputs. Values >= P are illegal and the result is unspecified.

Optional Feature:
- Macro: PRI_SEL_REG_OUT_EN.
- Defined:
  - `out` and `req_out` are registered on clk, giving 1-cycle latency.
  - Both reset synchronously to 0.
  - `ptr` still updates from the combinational (pre-register) grant.
- Undefined: outputs are purely combinational, as described above.

Decomposition:
- Package pri_sel_pkg holds:
  - the default N/P constants;
  - the typedef pri_t (logic [$clog2(P)-1:0]) for the default P;
  - a helper function for the cyclic-index increment.
- Sub-module rr_tie_arb (parameter N) takes an N-bit candidate mask (in[i]==max) and `ptr`, and returns the one-hot grant and the winner index.
- Top level: max-reduction tree, candidate mask, rr_tie_arb, ptr register, optional output register.

Test Plan:
- Unique max: after reset, in={3,9,5,1} -> out=9, req_out=4'b0010; the next edge sets ptr=2.
- Tie rotation: after reset, hold in={7,7,0,7} for 4 cycles -> req_out=0001, 0010, 1000, 0001; out=7 throughout.
- No request: in={0,0,0,0} -> out=0, req_out=0; ptr is unchanged across several edges (prior grant resumes afterwards).
- Wrap-around: with ptr=3 and in={15,2,2,15} -> req_out=1000, then ptr=0 -> next grant 0001.
- Reset mid-op: rotate the tie to ptr=2, assert reset for one edge with in={4,4,4,4} -> after the edge, req_out=0001.
- Random: 1000 random vectors of 4-bit values, checked against a reference model. Checks: out == max; req_out is one-hot (or zero iff all inputs are 0); the granted input equals max; round-robin order holds.
